// File: rtl/sdram_pkg.sv
// sdram_pkg: shared widths, arbiter FSM states and requester index type.
package sdram_pkg;
  localparam int SDRAM_ADDR_W = 23;
  localparam int SDRAM_DATA_W = 32;
  localparam int SDRAM_NUM_PORTS = 3;
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  // Two bits cover every supported port count (2..4).
  typedef logic [$clog2(SDRAM_NUM_PORTS)-1:0] port_idx_t;
endpackage

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: requester-side and controller-side signals of the SDRAM arbiter.
interface sdram_arbiter_if #(parameter int NUM_PORTS = 3);
  import sdram_pkg::*;
  logic [NUM_PORTS-1:0] req, req_rw, ack, rvalid;
  logic [NUM_PORTS*SDRAM_ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*SDRAM_DATA_W-1:0] req_wdata;
  logic [SDRAM_DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic [SDRAM_ADDR_W-1:0] mem_addr;
  logic err, mem_rw, mem_in_valid, mem_busy, mem_out_valid;
  modport slave (
    input  req, req_rw, req_addr, req_wdata, mem_busy, mem_rdata, mem_out_valid,
    output ack, rdata, rvalid, err, mem_addr, mem_rw, mem_wdata, mem_in_valid
  );
  modport master (
    output req, req_rw, req_addr, req_wdata, mem_busy, mem_rdata, mem_out_valid,
    input  ack, rdata, rvalid, err, mem_addr, mem_rw, mem_wdata, mem_in_valid
  );
endinterface

// File: rtl/sdram_arb_tag_fifo.sv
// sdram_arb_tag_fifo: in-order FIFO of requester indices for outstanding reads.
module sdram_arb_tag_fifo
  import sdram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  port_idx_t din,
  output port_idx_t dout,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  port_idx_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter of NUM_PORTS requesters onto one SDRAM controller port.
// Define SDRAM_ARB_PORT0_PRIO_EN to give port 0 strict priority over the rotating others.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int RD_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  sdram_arbiter_if.slave bus
);
  localparam logic [NUM_PORTS-1:0] ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};
  localparam port_idx_t LAST = port_idx_t'(NUM_PORTS-1);
  state_t state;
  port_idx_t winner, last_grant, pick, tag_out;
  logic full, empty, push, pop;
  logic [NUM_PORTS-1:0] elig;
  logic [SDRAM_ADDR_W-1:0] addr_a [NUM_PORTS];
  logic [SDRAM_DATA_W-1:0] wdata_a [NUM_PORTS];
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_split
    assign addr_a[g] = bus.req_addr[g*SDRAM_ADDR_W +: SDRAM_ADDR_W];
    assign wdata_a[g] = bus.req_wdata[g*SDRAM_DATA_W +: SDRAM_DATA_W];
  end
  // Reads are masked while every tag slot is in use; writes never are.
  assign elig = bus.req & (bus.req_rw | {NUM_PORTS{~full}});
  assign push = state == ISSUE && !bus.mem_rw;
  assign pop = bus.mem_out_valid && !empty;
  // Scan from farthest to nearest so the nearest eligible port after last_grant wins.
  always_comb begin
    pick = '0;
`ifdef SDRAM_ARB_PORT0_PRIO_EN
    for (int k = NUM_PORTS - 1; k >= 1; k--) begin
      port_idx_t c;
      c = port_idx_t'(1 + (int'(last_grant) - 1 + k) % (NUM_PORTS - 1));
      if (elig[c]) pick = c;
    end
    if (elig[0]) pick = '0;
`else
    for (int k = NUM_PORTS; k >= 1; k--) begin
      port_idx_t c;
      c = port_idx_t'((int'(last_grant) + k) % NUM_PORTS);
      if (elig[c]) pick = c;
    end
`endif
  end
  sdram_arb_tag_fifo #(.DEPTH(RD_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(winner),
    .dout(tag_out), .full(full), .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      winner <= '0;
      last_grant <= LAST;
      bus.ack <= '0;
      bus.mem_in_valid <= 1'b0;
      bus.mem_rw <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.rvalid <= '0;
      bus.rdata <= '0;
      bus.err <= 1'b0;
    end else begin
      bus.rvalid <= pop ? ONE << tag_out : '0;
      bus.rdata <= pop ? bus.mem_rdata : bus.rdata;
      bus.err <= bus.err | (bus.mem_out_valid & empty);
      case (state)
        IDLE:
          if (!bus.mem_busy && |elig) begin
            winner <= pick;
            bus.mem_rw <= bus.req_rw[pick];
            bus.mem_addr <= addr_a[pick];
            bus.mem_wdata <= wdata_a[pick];
            bus.mem_in_valid <= 1'b1;
            bus.ack <= ONE << pick;
            state <= ISSUE;
          end
        ISSUE: begin
          bus.mem_in_valid <= 1'b0;
          bus.ack <= '0;
`ifdef SDRAM_ARB_PORT0_PRIO_EN
          last_grant <= winner != '0 ? winner : last_grant;
`else
          last_grant <= winner;
`endif
          state <= HOLD;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed and randomized checks of sdram_arbiter against a queue-based reference model.
module tb_sdram_arbiter;
  import sdram_pkg::*;
  localparam int N = 3;
  localparam int D = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int q[$];
  int order[$];
  int acks[N];
  int pend = -1;
  int last_g = N - 1;
  int since = 2;
  int bcnt = 0;
  int busy_len = 0;
  logic [31:0] exp_rd = '0;
  logic exp_err = 1'b0;
  always #5 clk = ~clk;
  sdram_arbiter_if #(.NUM_PORTS(N)) bus();
  sdram_arbiter #(.NUM_PORTS(N), .RD_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int rr_pick(input logic [N-1:0] e, input int lg);
`ifdef SDRAM_ARB_PORT0_PRIO_EN
    if (e[0]) return 0;
    for (int k = 1; k < N; k++)
      if (e[1 + (lg - 1 + k) % (N - 1)]) return 1 + (lg - 1 + k) % (N - 1);
`else
    for (int k = 1; k <= N; k++)
      if (e[(lg + k) % N]) return (lg + k) % N;
`endif
    return -1;
  endfunction
  // One clock: predict from the current drives, advance to the next negedge, compare, update the model.
  task automatic cycle();
    logic [N-1:0] e, ev, ea_ack;
    logic [22:0] ea;
    logic [31:0] ew, nrd;
    logic erw;
    int p;
    for (int i = 0; i < N; i++) e[i] = bus.req[i] && (bus.req_rw[i] || q.size() < D);
    p = (since >= 2 && !bus.mem_busy) ? rr_pick(e, last_g) : -1;
    ea = '0; ew = '0; erw = 1'b0; ea_ack = '0;
    if (p >= 0) begin
      ea = bus.req_addr[p*23 +: 23];
      ew = bus.req_wdata[p*32 +: 32];
      erw = bus.req_rw[p];
      ea_ack[p] = 1'b1;
    end
    ev = '0;
    nrd = exp_rd;
    if (bus.mem_out_valid) begin
      if (q.size() > 0) begin
        ev[q.pop_front()] = 1'b1;
        nrd = bus.mem_rdata;
      end else exp_err = 1'b1;
    end
    if (pend >= 0) q.push_back(pend);
    pend = -1;
    @(negedge clk);
    chk("ack", bus.ack, ea_ack);
    chk("in_valid", bus.mem_in_valid, p >= 0);
    if (p >= 0) begin
      chk("mem_addr", bus.mem_addr, ea);
      chk("mem_rw", bus.mem_rw, erw);
      if (erw) chk("mem_wdata", bus.mem_wdata, ew);
      else pend = p;
      acks[p]++;
      order.push_back(p);
      bus.req[p] = 1'b0;
`ifdef SDRAM_ARB_PORT0_PRIO_EN
      if (p != 0) last_g = p;
`else
      last_g = p;
`endif
    end
    chk("rvalid", bus.rvalid, ev);
    chk("rdata", bus.rdata, nrd);
    chk("err", bus.err, exp_err);
    exp_rd = nrd;
    since = (p >= 0) ? 0 : since + 1;
    if (p >= 0) bcnt = busy_len;
    bus.mem_busy = bcnt > 0;
    if (bcnt > 0) bcnt--;
    bus.mem_out_valid = 1'b0;
  endtask
  task automatic do_reset(input int cycles);
    bus.req = '0;
    bus.mem_out_valid = 1'b0;
    bus.mem_busy = 1'b0;
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    chk("rst_ack", bus.ack, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_in_valid", bus.mem_in_valid, 0);
    chk("rst_mem_rw", bus.mem_rw, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    q.delete();
    order.delete();
    for (int i = 0; i < N; i++) acks[i] = 0;
    pend = -1; last_g = N - 1; since = 2; bcnt = 0; busy_len = 0;
    exp_rd = '0; exp_err = 1'b0;
  endtask
  initial begin
    int w[N];
    int maxw;
    int exp_order[6];
    bus.req = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_busy = 1'b0; bus.mem_rdata = '0; bus.mem_out_valid = 1'b0;
    do_reset(2);
    // Single read from port 1 and its data return.
    bus.req_rw[1] = 1'b0;
    bus.req_addr[23 +: 23] = 23'h000123;
    bus.req[1] = 1'b1;
    cycle();
    chk("t1_ack", bus.ack, 3'b010);
    chk("t1_addr", bus.mem_addr, 23'h000123);
    cycle();
    bus.mem_out_valid = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    cycle();
    chk("t1_rvalid", bus.rvalid, 3'b010);
    chk("t1_rdata", bus.rdata, 32'hDEADBEEF);
    // Continuous writes from every port with a slow controller.
    do_reset(1);
    for (int i = 0; i < N; i++) begin
      bus.req_rw[i] = 1'b1;
      bus.req_addr[i*23 +: 23] = 23'(32'h100 * (i + 1));
      bus.req_wdata[i*32 +: 32] = 32'hA000_0000 + i;
    end
    busy_len = 4;
    repeat (45) begin
      bus.req = '1;
      cycle();
    end
`ifdef SDRAM_ARB_PORT0_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 0, 1, 2};
`endif
    chk("t2_count", order.size() >= 6, 1);
    for (int i = 0; i < 6 && i < order.size(); i++) chk("t2_order", order[i], exp_order[i]);
    // Read tags full: third read waits for a return while a write slips through.
    do_reset(1);
    bus.req_rw[0] = 1'b0; bus.req_addr[0 +: 23] = 23'h10;
    bus.req_rw[2] = 1'b1; bus.req_addr[46 +: 23] = 23'h20; bus.req_wdata[64 +: 32] = 32'h1234_5678;
    repeat (20) begin
      if (acks[0] < 3) bus.req[0] = 1'b1;
      if (acks[2] < 1) bus.req[2] = 1'b1;
      cycle();
    end
    chk("t3_reads_held", acks[0], 2);
    chk("t3_write_done", acks[2], 1);
    bus.mem_out_valid = 1'b1;
    bus.mem_rdata = $urandom;
    cycle();
    repeat (10) begin
      if (acks[0] < 3) bus.req[0] = 1'b1;
      cycle();
    end
    chk("t3_third_read", acks[0], 3);
    repeat (20) begin
      if (q.size() > 0) begin bus.mem_out_valid = 1'b1; bus.mem_rdata = $urandom; end
      cycle();
    end
`ifdef SDRAM_ARB_PORT0_PRIO_EN
    // Port 0 keeps every slot until it lets go.
    do_reset(1);
    bus.req_rw = '1;
    repeat (20) begin
      bus.req[0] = 1'b1; bus.req[1] = 1'b1;
      cycle();
    end
    chk("prio_p1_starved", acks[1], 0);
    chk("prio_p0_grants", acks[0] >= 5, 1);
    repeat (6) begin
      bus.req[0] = 1'b0; bus.req[1] = 1'b1;
      cycle();
    end
    chk("prio_p1_after_drop", acks[1] >= 1, 1);
`endif
    // Randomized traffic, returns and controller busy lengths.
    do_reset(1);
    maxw = 0;
    for (int i = 0; i < N; i++) w[i] = 0;
    repeat (600) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
          bus.req_rw[i] = 1'($urandom_range(0, 1));
          bus.req_addr[i*23 +: 23] = 23'($urandom);
          bus.req_wdata[i*32 +: 32] = $urandom;
          bus.req[i] = 1'b1;
        end else if (bus.req[i] && $urandom_range(0, 15) == 0) bus.req[i] = 1'b0;
        w[i] = bus.req[i] ? w[i] + 1 : 0;
        if (w[i] > maxw) maxw = w[i];
      end
      busy_len = $urandom_range(0, 3);
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        bus.mem_out_valid = 1'b1;
        bus.mem_rdata = $urandom;
      end
      cycle();
    end
    chk("rand_no_starve", maxw <= 300, 1);
    bus.req = '0;
    repeat (30) begin
      if (q.size() > 0) begin bus.mem_out_valid = 1'b1; bus.mem_rdata = $urandom; end
      cycle();
    end
    // Reset between issue and return, then a stray return raises sticky err.
    do_reset(1);
    bus.req_rw[1] = 1'b0;
    bus.req_addr[23 +: 23] = 23'h000456;
    bus.req[1] = 1'b1;
    cycle();
    chk("rst_mid_ack", bus.ack, 3'b010);
    do_reset(1);
    bus.mem_out_valid = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    cycle();
    chk("stray_no_rvalid", bus.rvalid, 0);
    chk("stray_err", bus.err, 1);
    repeat (4) cycle();
    chk("err_sticky", bus.err, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
